// File: rtl/iob_regfile_2p_ctrl.sv
// IOb-native initiator for the 2-port register file: issues registered writes,
// holds the read address and returns read data with valid/ready back-pressure.
module iob_regfile_2p_ctrl #(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned RDATA_W = DATA_W,
    parameter int unsigned RADDR_W = ADDR_W - $clog2(DATA_W / 8)
) (
    input  logic                                      clk_i,
    input  logic                                      cke_i,
    input  logic                                      arst_i,
    input  logic                                      iob_valid_i,
    input  logic [ADDR_W-1:0]                         iob_addr_i,
    input  logic [DATA_W-1:0]                         iob_wdata_i,
    input  logic [DATA_W/8-1:0]                       iob_wstrb_i,
    output logic                                      iob_ready_o,
    output logic                                      iob_rvalid_o,
    output logic [DATA_W-1:0]                         iob_rdata_o,
    input  logic                                      iob_rready_i,
    output logic                                      wen_o,
    output logic [RADDR_W+ADDR_W+DATA_W/8+DATA_W-1:0] req_o,
    input  logic [RDATA_W-1:0]                        resp_i,
    output logic                                      err_o,
    input  logic                                      err_clr_i
);

    localparam int unsigned WSTRB_W = DATA_W / 8;
    localparam int unsigned WADDR_W = ADDR_W;
    localparam int unsigned BOFF_W  = $clog2(WSTRB_W);
    localparam int unsigned NWORDS  = (N * W + DATA_W - 1) / DATA_W;
    localparam logic [ADDR_W-1:0] BOFF_MASK = ADDR_W'((1 << BOFF_W) - 1);

    typedef struct packed {
        logic [RADDR_W-1:0] raddr;
        logic [WADDR_W-1:0] waddr;
        logic [WSTRB_W-1:0] wstrb;
        logic [DATA_W-1:0]  wdata;
    } req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state_q, state_d;
    req_t   req_q, req_d;
    logic   wen_q, wen_d;
    logic   rerr_q, rerr_d;
    logic   err_q, err_d;

    logic [ADDR_W-1:0] widx;
    logic              rvalid;
    logic              acc;
    logic              is_rd;
    logic              oor;

    // Request decode
    assign rvalid = (state_q == S_RESP);
    assign widx   = iob_addr_i >> BOFF_W;
    assign is_rd  = (iob_wstrb_i == '0);
    assign oor    = (32'(widx) >= NWORDS);

    assign iob_ready_o = !rvalid | iob_rready_i;
    assign acc         = iob_valid_i & iob_ready_o & cke_i;

    // Next-state and registered output logic
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wen_d   = 1'b0;
        rerr_d  = rerr_q;
        err_d   = err_q;

        // Set wins over clear
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (acc && oor) begin
            err_d = 1'b1;
        end

        if (acc) begin
            if (is_rd) begin
                req_d.raddr = widx[RADDR_W-1:0];
                rerr_d      = oor;
            end else if (!oor) begin
                wen_d       = 1'b1;
                req_d.waddr = iob_addr_i & ~BOFF_MASK;
                req_d.wstrb = iob_wstrb_i;
                req_d.wdata = iob_wdata_i;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (acc && is_rd) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (iob_rready_i) begin
                    state_d = (acc && is_rd) ? S_RESP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; cke_i low freezes everything
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            wen_q   <= 1'b0;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            req_q   <= req_d;
            wen_q   <= wen_d;
            rerr_q  <= rerr_d;
            err_q   <= err_d;
        end
    end

    // A held wen_q must not write again while the clock is disabled
    assign wen_o        = wen_q & cke_i;
    assign req_o        = req_q;
    assign err_o        = err_q;
    assign iob_rvalid_o = rvalid;
    assign iob_rdata_o  = (rvalid && !rerr_q) ? DATA_W'(resp_i) : '0;

endmodule
